keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner for the PmodKYPD path. Drives one-cold column strobes, samples synchronised row inputs, and debounces whole-matrix scan images. It emits press/release events with a valid/ack handshake and flags multi-key presses. It replaces the fixed 4x4, decode-only scanner and feeds the lab control FSM, which consumes key events instead of a raw decode.

## Interface
- ROWS, 4: keypad rows (2..8)
- COLS, 4: keypad columns (2..8)
- COL_CYC, 100000: clk cycles each column is driven (1 ms at 100 MHz); must be > SETTLE_CYC
- SETTLE_CYC, 8: cycle index within a column slot at which rows are sampled; must be ≥ 3
- DEBOUNCE, 3: consecutive identical scans required to commit a new stable state (1..15)
- CODE_W, $clog2(ROWS*COLS): key code width
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- row  in  ROWS  row pins, active-low, asynchronous to clk
- col  out  COLS  column strobes, active-low, exactly one low at all times
- ev_valid  out  1  event pending; held until accepted
- ev_code  out  CODE_W  key code = r*COLS + c (r = row bit index, c = col bit index)
- ev_release  out  1  0 = press, 1 = release
- ev_ack  in  1  consumer accepts the event when ev_valid & ev_ack at a rising edge
- ev_overflow  out  1  one-cycle pulse: an event was dropped
- multi_key  out  1  level: the stable state is "more than one key down"

## Operation
- Row inputs pass through a 2-flop synchroniser; SETTLE_CYC covers the strobe settling time plus the synchroniser delay.
- Slot counter runs 0..COL_CYC-1. Column index runs 0..COLS-1 and advances with wrap when the counter wraps. col[c] is low only while the column index equals c.
- When slot count == SETTLE_CYC, synchronised ~row is written into scan image bits [c*ROWS +: ROWS].
- Scan complete fires on the last cycle of column COLS-1. The image is classified as:
  - NONE: zero bits set
  - KEY(k): exactly one bit set
  - MULTI: two or more bits set
- Debounce compares the classification with the previous scan's classification, including k for KEY.
  - If equal, the match counter increments, saturating at DEBOUNCE.
  - Otherwise the match counter is set to 1.
- Commit happens when the match counter is ≥ DEBOUNCE and the classification differs from the stable state. Commit rules:
  - NONE→KEY(k): press event k; stable becomes KEY(k).
  - KEY(k)→NONE or KEY(k)→MULTI: release event k; stable becomes the new classification.
  - KEY(k)→KEY(j), j≠k: release event k only; stable becomes NONE. The press of j commits at the next scan complete, because its counter is already satisfied.
  - MULTI→KEY(k): press event k. MULTI→NONE: no event.
- multi_key is high exactly while stable == MULTI.
- Event register is one deep:
  - A new event loads ev_code, ev_release and sets ev_valid when ev_valid is low, or when ev_valid & ev_ack in the same cycle.
  - Otherwise the new event is dropped and ev_overflow pulses; the pending event is unchanged.
  - Accepting an event with no new event arriving clears ev_valid.
- ev_code and ev_release are stable while ev_valid is high.

## Timing
- Reset (async assert, released on a clk edge) sets: col = all ones except bit 0 low; slot counter 0; column index 0; image 0; stable NONE; match counter 0; ev_valid 0; ev_code 0; ev_release 0; ev_overflow 0; multi_key 0.
- A reset assertion mid-scan discards the partial image and any pending event immediately.
- Full scan period = COLS*COL_CYC cycles. ev_valid and multi_key update on the edge after scan complete.
- Press latency: a key stable from the first sample of a scan produces ev_valid DEBOUNCE scans later, +1 cycle.
- Handshake: one event per accepted ack. ev_ack while ev_valid is low is ignored.

## Test plan
Configuration for all scenarios: ROWS=COLS=4, COL_CYC=16, SETTLE_CYC=4, DEBOUNCE=3. The keypad model pulls row[r] low while col[c] is low and key (r,c) is held.
- Reset/idle -> col=1110 after reset, then 1101, 1011, 0111 every 16 cycles, repeating every 64 cycles; ev_valid, multi_key and ev_overflow stay 0. Assert rst_n low mid-slot -> col=1110 and ev_valid=0 without waiting for clk.
- Hold key (1,2) for 5 scans with ev_ack tied high -> press with ev_code=6, ev_release=0, ev_valid high 1 cycle after the 3rd scan complete. Then release -> ev_code=6, ev_release=1, 3 scans later.
- Toggle key (0,0) on alternate scans for 8 scans -> no event. Hold key (0,0) 2 scans, then none -> no event.
- Hold keys (0,0) and (2,3) from idle -> multi_key=1 after 3 scans, no event. Drop (2,3) -> press ev_code=0 after 3 scans, multi_key=0.
- With ev_ack=0: press (3,3) then release -> ev_valid holds ev_code=15, ev_release=0; ev_overflow pulses once at the release commit. Ack -> ev_valid falls next cycle.
- Roll from (1,1) to (1,2) without a gap -> release 5 at the 3rd scan, then press 6 at the following scan complete, each acked in order.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes one column at a time, debounces whole-matrix
// scan images and reports press/release events through a one-deep event buffer.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int COL_CYC    = 100000,
  parameter int SETTLE_CYC = 8,
  parameter int DEBOUNCE   = 3,
  parameter int CODE_W     = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              ev_valid,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_release,
  input  logic              ev_ack,
  output logic              ev_overflow,
  output logic              multi_key
);

  localparam int SLOT_W = $clog2(COL_CYC);
  localparam int COL_W  = $clog2(COLS);
  localparam int NKEYS  = ROWS * COLS;

  typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_MULTI} cls_e;

  logic [ROWS-1:0]   rowMeta_q, rowSync_q;
  logic [SLOT_W-1:0] slot_q;
  logic [COL_W-1:0]  colIdx_q;
  logic [NKEYS-1:0]  image_q;
  cls_e              prevCls_q, stableCls_q;
  logic [CODE_W-1:0] prevCode_q, stableCode_q;
  logic [3:0]        matchCnt_q;
  logic              evValid_q, evRelease_q, evOverflow_q;
  logic [CODE_W-1:0] evCode_q;

  logic              slotEnd, scanDone;
  logic [1:0]        bitCount;
  cls_e              scanCls;
  logic [CODE_W-1:0] scanCode;
  logic              sameAsPrev, differsFromStable, commit;
  logic [3:0]        matchCnt_d;
  cls_e              stableCls_d;
  logic [CODE_W-1:0] stableCode_d;
  logic              newEv, newRel;
  logic [CODE_W-1:0] newCode;

  assign slotEnd  = (slot_q == SLOT_W'(COL_CYC - 1));
  assign scanDone = slotEnd && (colIdx_q == COL_W'(COLS - 1));

  assign col         = ~(COLS'(1) << colIdx_q);
  assign ev_valid    = evValid_q;
  assign ev_code     = evCode_q;
  assign ev_release  = evRelease_q;
  assign ev_overflow = evOverflow_q;
  assign multi_key   = (stableCls_q == CLS_MULTI);

  // Image bit order is column-major (c*ROWS + r) but key codes are row-major.
  always_comb begin
    bitCount = 2'd0;
    scanCode = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (image_q[c*ROWS + r]) begin
          if (bitCount != 2'd2) bitCount = bitCount + 2'd1;
          scanCode = CODE_W'(r*COLS + c);
        end
      end
    end
    case (bitCount)
      2'd0:    scanCls = CLS_NONE;
      2'd1:    scanCls = CLS_KEY;
      default: scanCls = CLS_MULTI;
    endcase
  end

  always_comb begin
    sameAsPrev = (scanCls == prevCls_q) && ((scanCls != CLS_KEY) || (scanCode == prevCode_q));
    if (!sameAsPrev)                       matchCnt_d = 4'd1;
    else if (matchCnt_q >= 4'(DEBOUNCE))   matchCnt_d = 4'(DEBOUNCE);
    else                                   matchCnt_d = matchCnt_q + 4'd1;

    differsFromStable = (scanCls != stableCls_q) ||
                        ((scanCls == CLS_KEY) && (scanCode != stableCode_q));
    commit = scanDone && (matchCnt_d >= 4'(DEBOUNCE)) && differsFromStable;

    stableCls_d  = stableCls_q;
    stableCode_d = stableCode_q;
    newEv        = 1'b0;
    newRel       = 1'b0;
    newCode      = scanCode;
    if (commit) begin
      stableCls_d  = scanCls;
      stableCode_d = scanCode;
      case (stableCls_q)
        CLS_KEY: begin
          newEv   = 1'b1;
          newRel  = 1'b1;
          newCode = stableCode_q;
          // A roll to another key only releases; the new press follows next scan.
          if (scanCls == CLS_KEY) stableCls_d = CLS_NONE;
        end
        default: newEv = (scanCls == CLS_KEY);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowMeta_q    <= '1;
      rowSync_q    <= '1;
      slot_q       <= '0;
      colIdx_q     <= '0;
      image_q      <= '0;
      prevCls_q    <= CLS_NONE;
      prevCode_q   <= '0;
      stableCls_q  <= CLS_NONE;
      stableCode_q <= '0;
      matchCnt_q   <= '0;
      evValid_q    <= 1'b0;
      evCode_q     <= '0;
      evRelease_q  <= 1'b0;
      evOverflow_q <= 1'b0;
    end else begin
      rowMeta_q <= row;
      rowSync_q <= rowMeta_q;

      if (slotEnd) begin
        slot_q   <= '0;
        colIdx_q <= (colIdx_q == COL_W'(COLS - 1)) ? '0 : colIdx_q + COL_W'(1);
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end

      if (slot_q == SLOT_W'(SETTLE_CYC)) begin
        for (int c = 0; c < COLS; c++) begin
          if (colIdx_q == COL_W'(c)) image_q[c*ROWS +: ROWS] <= ~rowSync_q;
        end
      end

      if (scanDone) begin
        prevCls_q    <= scanCls;
        prevCode_q   <= scanCode;
        matchCnt_q   <= matchCnt_d;
        stableCls_q  <= stableCls_d;
        stableCode_q <= stableCode_d;
      end

      evOverflow_q <= 1'b0;
      if (newEv) begin
        if (!evValid_q || ev_ack) begin
          evValid_q   <= 1'b1;
          evCode_q    <= newCode;
          evRelease_q <= newRel;
        end else begin
          evOverflow_q <= 1'b1;
        end
      end else if (ev_ack) begin
        evValid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives the rows, expected
// events go into a queue and a monitor pops them as the DUT's events are accepted.
module tb_keypad_scanner;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int COL_CYC    = 16;
  localparam int SETTLE_CYC = 4;
  localparam int DEBOUNCE   = 3;
  localparam int CODE_W     = 4;
  localparam int SCAN_CYC   = COLS * COL_CYC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ev_ack = 1'b0;
  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   col;
  logic              ev_valid;
  logic [CODE_W-1:0] ev_code;
  logic              ev_release;
  logic              ev_overflow;
  logic              multi_key;
  logic [15:0]       keyHeld = '0;

  typedef struct packed {
    logic [3:0] code;
    logic       rel;
  } ev_t;

  ev_t expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  overflowSeen = 0;
  int  expOverflow = 0;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .COL_CYC(COL_CYC),
    .SETTLE_CYC(SETTLE_CYC), .DEBOUNCE(DEBOUNCE), .CODE_W(CODE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_release(ev_release),
    .ev_ack(ev_ack), .ev_overflow(ev_overflow), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (keyHeld[r*COLS + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    keyHeld = keys;
  endtask

  task automatic expectEvent(input int code, input logic rel);
    ev_t e;
    e.code = 4'(code);
    e.rel  = rel;
    expQ.push_back(e);
  endtask

  task automatic runScans(input int n);
    repeat (n * SCAN_CYC) @(negedge clk);
  endtask

  // Samples just after the negedge, so ack and outputs are settled before the next posedge.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (ev_overflow) overflowSeen++;
        if (ev_valid && ev_ack) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event: got code %0d release %0d, expected none", ev_code, ev_release);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_code", 32'(ev_code), 32'(e.code));
            checkOutput("sb_release", 32'(ev_release), 32'(e.rel));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expCol;
    $display("[TB] start");
    #12;
    checkOutput("reset_col", 32'(col), 32'(4'b1110));
    checkOutput("reset_valid", 32'(ev_valid), 0);
    checkOutput("reset_multi", 32'(multi_key), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Column strobe rotation over two idle scans
    for (int i = 0; i < 8; i++) begin
      expCol = 4'b1111 ^ (4'b0001 << (i % 4));
      checkOutput("col_seq", 32'(col), 32'(expCol));
      repeat (COL_CYC) @(negedge clk);
    end
    checkOutput("idle_valid", 32'(ev_valid), 0);
    checkOutput("idle_multi", 32'(multi_key), 0);

    // Press and release key (1,2) with ack held high
    ev_ack = 1'b1;
    applyStimulus(16'h0040);
    expectEvent(6, 1'b0);
    runScans(2);
    checkOutput("press_early", 32'(ev_valid), 0);
    runScans(1);
    checkOutput("press_valid", 32'(ev_valid), 1);
    checkOutput("press_code", 32'(ev_code), 6);
    checkOutput("press_rel", 32'(ev_release), 0);
    runScans(2);
    applyStimulus(16'h0000);
    expectEvent(6, 1'b1);
    runScans(3);
    checkOutput("release_valid", 32'(ev_valid), 1);
    checkOutput("release_rel", 32'(ev_release), 1);
    runScans(1);

    // Bouncing key (0,0) must never commit
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? 16'h0001 : 16'h0000);
      runScans(1);
    end
    applyStimulus(16'h0001);
    runScans(2);
    applyStimulus(16'h0000);
    runScans(3);
    checkOutput("bounce_valid", 32'(ev_valid), 0);

    // Two keys down, then drop one
    applyStimulus(16'h0801);
    runScans(2);
    checkOutput("multi_early", 32'(multi_key), 0);
    runScans(1);
    checkOutput("multi_set", 32'(multi_key), 1);
    checkOutput("multi_noev", 32'(ev_valid), 0);
    applyStimulus(16'h0001);
    expectEvent(0, 1'b0);
    runScans(2);
    checkOutput("multi_hold", 32'(multi_key), 1);
    runScans(1);
    checkOutput("multi_clear", 32'(multi_key), 0);
    checkOutput("multi_press_valid", 32'(ev_valid), 1);
    checkOutput("multi_press_code", 32'(ev_code), 0);
    applyStimulus(16'h0000);
    expectEvent(0, 1'b1);
    runScans(4);

    // Unacknowledged press followed by release overflows
    ev_ack = 1'b0;
    applyStimulus(16'h8000);
    expectEvent(15, 1'b0);
    runScans(3);
    checkOutput("hold_valid", 32'(ev_valid), 1);
    applyStimulus(16'h0000);
    expOverflow++;
    runScans(3);
    checkOutput("hold_valid2", 32'(ev_valid), 1);
    checkOutput("hold_code", 32'(ev_code), 15);
    checkOutput("hold_rel", 32'(ev_release), 0);
    ev_ack = 1'b1;
    @(negedge clk);
    checkOutput("ack_clears", 32'(ev_valid), 0);
    checkOutput("overflow_count", 32'(overflowSeen), 32'(expOverflow));
    repeat (SCAN_CYC - 1) @(negedge clk);

    // Roll from (1,1) to (1,2)
    applyStimulus(16'h0020);
    expectEvent(5, 1'b0);
    runScans(4);
    applyStimulus(16'h0040);
    expectEvent(5, 1'b1);
    expectEvent(6, 1'b0);
    runScans(3);
    checkOutput("roll_rel_valid", 32'(ev_valid), 1);
    checkOutput("roll_rel_code", 32'(ev_code), 5);
    checkOutput("roll_rel_rel", 32'(ev_release), 1);
    runScans(1);
    checkOutput("roll_press_valid", 32'(ev_valid), 1);
    checkOutput("roll_press_code", 32'(ev_code), 6);
    checkOutput("roll_press_rel", 32'(ev_release), 0);
    applyStimulus(16'h0000);
    expectEvent(6, 1'b1);
    runScans(4);

    // Reset mid-slot drops the pending event without a clock edge
    ev_ack = 1'b0;
    applyStimulus(16'h0001);
    runScans(3);
    checkOutput("pend_valid", 32'(ev_valid), 1);
    repeat (20) @(negedge clk);
    checkOutput("mid_col", 32'(col), 32'(4'b1101));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_col", 32'(col), 32'(4'b1110));
    checkOutput("async_valid", 32'(ev_valid), 0);
    applyStimulus(16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    ev_ack = 1'b1;
    runScans(4);
    checkOutput("post_reset_valid", 32'(ev_valid), 0);
    checkOutput("post_reset_multi", 32'(multi_key), 0);

    checkOutput("queue_drained", 32'(expQ.size()), 0);
    checkOutput("overflow_final", 32'(overflowSeen), 32'(expOverflow));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
